issue_queue: RTL
================

# issue_queue

Dual-ported in-order instruction queue between Decode and the Issue Unit. Accepts up to two decoded slots per cycle, buffers them in a circular store, and presents the oldest one or two entries to the Issue Unit. It decides whether the head pair may dual-issue or the head must issue alone. Decouples decode from issue stalls and flushes on branch redirect.

## Interface
Parameters:
- WIDTH, 32, datapath width (imm, PC).
- DEPTH, 8, queue entries; power of two, at least 4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (branch/jump redirect).
- in_valid  in  2  slot valid; [0] is the older instruction.
- in_slot  in  decoded_slot_t[1:0]  decoded instructions from Decode.
- in_ready  out  1  queue can accept two slots this cycle.
- out_valid  out  2  [0] head presented; [1] head+1 presented and pairable.
- out_slot  out  decoded_slot_t[1:0]  head / head+1 entries; [0] is older.
- issue_ready  in  1  Issue Unit consumes every presented valid slot this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage: DEPTH entries of decoded_slot_t, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH; count held separately.
- Push: accepted only when in_ready=1. Valid slots are written in age order at wr_ptr, wr_ptr+1, compacted, so in_valid=2'b10 writes slot[1] at wr_ptr. push_n = popcount(in_valid).
- in_ready = (DEPTH - count) >= 2, computed from the registered count. Pops in the same cycle are not credited.
- out_slot[0] = entry[rd_ptr]. out_slot[1] = entry[rd_ptr+1].
- out_valid[0] = count >= 1.
- out_valid[1] = count >= 2 AND pairable. Pairable only if all of the following hold:
  - head is not branch/JAL/JALR;
  - not both memory ops (load or store);
  - not both control-transfer;
  - no RAW inside the pair: head.rf_write with rd_idx != 0 and rd_idx equal to second.rs1_idx or second.rs2_idx breaks the pair.
- Pop: pop_n = issue_ready ? popcount(out_valid) : 0. rd_ptr += pop_n.
- count_next = count + push_n - pop_n. Simultaneous push and pop are legal.
- flush: next edge sets rd_ptr = wr_ptr = 0 and count = 0. Pushes in the flush cycle are dropped. out_valid is forced 2'b00 combinationally while flush=1.
- Overflow is impossible by construction. A push with in_ready=0 is ignored, and the bench flags it as a protocol error.

## Timing
- Reset values: pointers 0, count 0, out_valid 2'b00, in_ready 1. Entry contents are don't-care but must never be presented while invalid.
- Push-to-present latency: 1 cycle. A slot written at edge N is visible on out_slot after edge N.
- Pop is effective at the same edge that samples issue_ready=1. The next entries are presented in the following cycle, giving 2 instructions/cycle throughput when pairable.
- Empty: out_valid=00; issue_ready is ignored.
- count=1: only out_valid[0] can be set.
- Full (count=DEPTH): in_ready=0. in_ready also drops at count=DEPTH-1.
- Wrap: head at DEPTH-1 pairs with entry 0.
- Reset asserted mid-operation clears state immediately (asynchronous). First pushes are accepted on the first edge after rst_n deasserts.

## Structure
- Shared package/header holds decoded_slot_t:
  - rs1_idx, rs2_idx, rd_idx [4:0];
  - imm, pc [WIDTH-1:0];
  - alu_op [ALU_OP-1:0];
  - shift_size [4:0];
  - load_type [LOAD_TYPE-1:0];
  - store_type [1:0];
  - rf_write, mem_read, mem_write, branch, jal, jalr.
- The package also holds the constants WIDTH, ALU_OP and LOAD_TYPE already used by the Issue Unit.
- One natural sub-module, issue_pair_check: purely combinational, taking two decoded_slot_t and returning pairable. It is reused by the Issue Unit's hazard logic.

## Test plan
- Reset then push two ADDs (rd=x1 from x2; rd=x3 from x4), issue_ready=1 → next cycle out_valid=11; the following cycle count=0, out_valid=00.
- Push LW x5 then SW x6 → out_valid=01. Two issue cycles are needed: LW, then SW.
- Push ADD x7,x1,x2 then SUB x8,x7,x3 → RAW detected, out_valid=01. Same pair with rd=x0 → out_valid=11.
- Hold issue_ready=0 and push pairs until count=7 → in_ready=0 from count=7. Then release and drain across the 7→0 wrap with correct PC order.
- With count=5, assert flush together with in_valid=11 → next cycle count=0, out_valid=00, and the pushed pair is dropped.
- Assert rst_n=0 asynchronously at mid-clock with count=4 → count, out_valid and in_ready are 0, 00 and 1 before the next edge.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared decode/issue types: the decoded instruction slot and the constants
// the Issue Unit already depends on.
package issue_queue_pkg;

  localparam int WIDTH     = 32;
  localparam int ALU_OP    = 4;
  localparam int LOAD_TYPE = 3;

  typedef struct packed {
    logic [4:0]           rs1_idx;
    logic [4:0]           rs2_idx;
    logic [4:0]           rd_idx;
    logic [WIDTH-1:0]     imm;
    logic [WIDTH-1:0]     pc;
    logic [ALU_OP-1:0]    alu_op;
    logic [4:0]           shift_size;
    logic [LOAD_TYPE-1:0] load_type;
    logic [1:0]           store_type;
    logic                 rf_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch;
    logic                 jal;
    logic                 jalr;
  } decoded_slot_t;

  function automatic logic is_ctrl(decoded_slot_t s);
    return s.branch | s.jal | s.jalr;
  endfunction

  function automatic logic is_mem(decoded_slot_t s);
    return s.mem_read | s.mem_write;
  endfunction

  function automatic logic [1:0] popcount2(logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether two in-order slots may issue together in the same cycle.
// Shared with the Issue Unit's hazard logic.
module issue_pair_check
  import issue_queue_pkg::*;
(
  input  decoded_slot_t head,
  input  decoded_slot_t second,
  output logic          pairable
);

  logic raw;
  logic unused_fields;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  assign raw = head.rf_write && (head.rd_idx != 5'd0) &&
               ((head.rd_idx == second.rs1_idx) || (head.rd_idx == second.rs2_idx));

  assign pairable = !is_ctrl(head) &&
                    !(is_mem(head) && is_mem(second)) &&
                    !(is_ctrl(head) && is_ctrl(second)) &&
                    !raw;

  assign unused_fields = ^{head, second};

endmodule

// File: rtl/issue_queue.sv
// In-order dual-ported instruction queue between Decode and the Issue Unit;
// presents the oldest one or two entries and flushes on redirect.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int WIDTH = issue_queue_pkg::WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [1:0]                 in_valid,
  input  decoded_slot_t [1:0]        in_slot,
  output logic                       in_ready,
  output logic [1:0]                 out_valid,
  output decoded_slot_t [1:0]        out_slot,
  input  logic                       issue_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (WIDTH != issue_queue_pkg::WIDTH) begin : g_bad_width
    $error("issue_queue: WIDTH must match the decoded_slot_t datapath width");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("issue_queue: DEPTH must be a power of two and at least 4");
  end

  decoded_slot_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [1:0]    push_n, pop_n;
  logic          push_en;
  logic          pairable;

  assign wr_ptr_p1 = wr_ptr + PW'(1);
  assign rd_ptr_p1 = rd_ptr + PW'(1);

  assign out_slot[0] = mem[rd_ptr];
  assign out_slot[1] = mem[rd_ptr_p1];

  issue_pair_check u_pair_check (
    .head     (out_slot[0]),
    .second   (out_slot[1]),
    .pairable (pairable)
  );

  // Room is judged from the registered count only; same-cycle pops are not credited.
  assign in_ready     = count <= CW'(DEPTH - 2);
  assign out_valid[0] = !flush && (count != '0);
  assign out_valid[1] = !flush && (count >= CW'(2)) && pairable;

  assign push_en = in_ready && !flush;
  assign push_n  = push_en ? popcount2(in_valid) : 2'd0;
  assign pop_n   = issue_ready ? popcount2(out_valid) : 2'd0;

  // NOTE: storage has no reset; out_valid gating keeps stale entries from ever being presented.
  always_ff @(posedge clk) begin
    if (push_en) begin
      if (in_valid[0]) begin
        mem[wr_ptr] <= in_slot[0];
        if (in_valid[1]) mem[wr_ptr_p1] <= in_slot[1];
      end else if (in_valid[1]) begin
        mem[wr_ptr] <= in_slot[1];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

endmodule
